// File: rtl/uart_csr_host_if.sv
// CSR bus between the UART CSR host (master) and the UART CSR bank (slave).
// Read data is registered by the slave and is valid the cycle after ren.
interface uart_csr_host_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wen;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              ren;

    modport master (
        output wr_addr,
        output wr_data,
        output wen,
        output rd_addr,
        output ren,
        input  rd_data
    );

    modport slave (
        input  wr_addr,
        input  wr_data,
        input  wen,
        input  rd_addr,
        input  ren,
        output rd_data
    );
endinterface

// File: rtl/uart_csr_host.sv
// UART CSR host: programs baud/control after reset, pushes tx bytes through SEND_DATA plus the
// CONTROL send bit, and periodically polls STATUS to pull received bytes out of READ_DATA.
// One CSR access per FSM state; strobes are decoded from the current state.
module uart_csr_host #(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BAUD_ADDR = 8'h00,
    parameter logic [ADDR_W-1:0] CTRL_ADDR = 8'h01,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 8'h02,
    parameter logic [ADDR_W-1:0] SEND_ADDR = 8'h03,
    parameter logic [ADDR_W-1:0] READ_ADDR = 8'h04,
    parameter logic [DATA_W-1:0] BAUD_INIT = 32'd5208,
    parameter logic [DATA_W-1:0] CTRL_INIT = 32'h8,
    parameter int unsigned       SEND_BIT  = 0,
    parameter int unsigned       DV_BIT    = 0,
    parameter int unsigned       PERR_BIT  = 1,
    parameter int unsigned       POLL_IVL  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    uart_csr_host_if.master csr,
    input  logic [7:0]      tx_data_i,
    input  logic            tx_valid_i,
    output logic            tx_ready_o,
    output logic [7:0]      rx_data_o,
    output logic            rx_valid_o,
    input  logic            rx_ready_i,
    output logic            parity_err_o,
    output logic            init_done_o
);

    localparam int unsigned       CntW      = $clog2(POLL_IVL + 1);
    localparam logic [CntW-1:0]   CntReload = CntW'(POLL_IVL);
    localparam logic [DATA_W-1:0] SendMask  = {{(DATA_W-1){1'b0}}, 1'b1} << SEND_BIT;

    typedef enum logic [3:0] {
        StInitBaud,
        StInitCtrl,
        StIdle,
        StTxData,
        StTxGo,
        StTxRd,
        StTxChk,
        StStRd,
        StStChk,
        StRxRd,
        StRxChk,
        StRxOut
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            perr_q, perr_d;
    logic            init_done_q, init_done_d;

    logic              wen, ren, tx_ready;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;

    // Only a few rd_data bits are decoded; fold the rest so they count as consumed.
    logic unused_rd_data;
    assign unused_rd_data = ^csr.rd_data;

    // Next-state and strobe decode; everything is held inactive while reset is asserted.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_byte_d   = tx_byte_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        perr_d      = perr_q;
        init_done_d = init_done_q;
        wen         = 1'b0;
        ren         = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_addr     = '0;
        tx_ready    = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                StInitBaud: begin
                    wen     = 1'b1;
                    wr_addr = BAUD_ADDR;
                    wr_data = BAUD_INIT;
                    state_d = StInitCtrl;
                end
                StInitCtrl: begin
                    wen         = 1'b1;
                    wr_addr     = CTRL_ADDR;
                    wr_data     = CTRL_INIT;
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end
                StIdle: begin
                    tx_ready = (cnt_q != '0);
                    // An expired poll interval wins over tx so rx is never starved.
                    if (cnt_q == '0) begin
                        state_d = StStRd;
                    end else if (tx_valid_i) begin
                        tx_byte_d = tx_data_i;
                        state_d   = StTxData;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StTxData: begin
                    wen     = 1'b1;
                    wr_addr = SEND_ADDR;
                    wr_data = DATA_W'(tx_byte_q);
                    state_d = StTxGo;
                end
                StTxGo: begin
                    wen     = 1'b1;
                    wr_addr = CTRL_ADDR;
                    wr_data = CTRL_INIT | SendMask;
                    state_d = StTxRd;
                end
                StTxRd: begin
                    ren     = 1'b1;
                    rd_addr = CTRL_ADDR;
                    state_d = StTxChk;
                end
                StTxChk: begin
                    // The UART clears send_data once the byte has left; keep polling until then.
                    state_d = csr.rd_data[SEND_BIT] ? StTxRd : StIdle;
                end
                StStRd: begin
                    ren     = 1'b1;
                    rd_addr = STAT_ADDR;
                    state_d = StStChk;
                end
                StStChk: begin
                    if (csr.rd_data[PERR_BIT]) begin
                        perr_d = 1'b1;
                    end
                    if (csr.rd_data[DV_BIT]) begin
                        state_d = StRxRd;
                    end else begin
                        cnt_d   = CntReload;
                        state_d = StIdle;
                    end
                end
                StRxRd: begin
                    ren     = 1'b1;
                    rd_addr = READ_ADDR;
                    state_d = StRxChk;
                end
                StRxChk: begin
                    rx_data_d  = csr.rd_data[7:0];
                    rx_valid_d = 1'b1;
                    state_d    = StRxOut;
                end
                StRxOut: begin
                    if (rx_ready_i) begin
                        rx_valid_d = 1'b0;
                        cnt_d      = CntReload;
                        state_d    = StIdle;
                    end
                end
                default: begin
                    state_d = StInitBaud;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StInitBaud;
            cnt_q       <= CntReload;
            tx_byte_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            perr_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_byte_q   <= tx_byte_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            perr_q      <= perr_d;
            init_done_q <= init_done_d;
        end
    end

    assign csr.wen      = wen;
    assign csr.ren      = ren;
    assign csr.wr_addr  = wr_addr;
    assign csr.wr_data  = wr_data;
    assign csr.rd_addr  = rd_addr;
    assign tx_ready_o   = tx_ready;
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign parity_err_o = perr_q;
    assign init_done_o  = init_done_q;

endmodule

// File: tb/tb_uart_csr_host.sv
// Bench for uart_csr_host: a behavioural CSR bank answers reads, a bus monitor pops expected
// CSR operations from a scoreboard queue, and table-driven tx/rx cases plus hand sequences
// cover poll priority, sticky parity error and reset mid-transfer.
module tb_uart_csr_host;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_csr_host_if #(.ADDR_W(8), .DATA_W(32)) csr_if ();

    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       parity_err, init_done;

    uart_csr_host #(.POLL_IVL(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .csr          (csr_if),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .parity_err_o (parity_err),
        .init_done_o  (init_done)
    );

    typedef struct packed {
        logic        w;
        logic [7:0]  addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        logic [7:0] data;
        int         busy;
        int         lat;
    } tx_vec_t;

    typedef struct {
        logic [31:0] stat;
        logic [31:0] rdv;
        logic [7:0]  exp_data;
    } rx_vec_t;

    int  total = 0;
    int  bad   = 0;
    op_t exp_q[$];
    bit  strict = 1'b0;
    int  op_cnt = 0;
    int  stat_cnt = 0;
    int  ctrl_rd_cnt = 0;

    // CSR bank model stimulus knobs (written by the main flow only)
    int          busy_cfg = 0;
    int          rx_req = 0;
    logic [31:0] rx_stat = '0;
    logic [31:0] rx_val = '0;
    // CSR bank model state (written by the model only)
    int          busy_left = 0;
    int          rx_served = 0;

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string msg);
        total++;
        bad++;
        $display("FAIL %s", msg);
    endtask

    task automatic exp_op(input logic w, input logic [7:0] a, input logic [31:0] d);
        op_t o;
        o.w    = w;
        o.addr = a;
        o.data = d;
        exp_q.push_back(o);
    endtask

    // Registered read data; send_data clears after busy_cfg busy polls; one rx event per request.
    always @(posedge clk) begin
        if (rst) begin
            busy_left      <= 0;
            csr_if.rd_data <= '0;
        end else begin
            if (csr_if.wen && csr_if.wr_addr == 8'h01 && csr_if.wr_data[0]) begin
                busy_left <= busy_cfg;
            end
            if (csr_if.ren) begin
                if (csr_if.rd_addr == 8'h01) begin
                    csr_if.rd_data <= (busy_left > 0) ? 32'h9 : 32'h8;
                    if (busy_left > 0) busy_left <= busy_left - 1;
                end else if (csr_if.rd_addr == 8'h02) begin
                    if (rx_req != rx_served) begin
                        csr_if.rd_data <= rx_stat;
                        if (!rx_stat[0]) rx_served <= rx_served + 1;
                    end else begin
                        csr_if.rd_data <= '0;
                    end
                end else if (csr_if.rd_addr == 8'h04) begin
                    csr_if.rd_data <= rx_val;
                    if (rx_req != rx_served) rx_served <= rx_served + 1;
                end else begin
                    csr_if.rd_data <= 32'hDEAD_BEEF;
                end
            end
        end
    end

    task automatic mon_step();
        op_t cur;
        op_t e;
        if (!rst && (csr_if.wen || csr_if.ren)) begin
            op_cnt++;
            check("wen_ren_exclusive", {72'b0, csr_if.wen & csr_if.ren}, 73'b0);
            cur.w    = csr_if.wen;
            cur.addr = csr_if.wen ? csr_if.wr_addr : csr_if.rd_addr;
            cur.data = csr_if.wen ? csr_if.wr_data : 32'h0;
            if (!cur.w && cur.addr == 8'h02) stat_cnt++;
            if (!cur.w && cur.addr == 8'h01) ctrl_rd_cnt++;
            // Background status polls are only scoreboarded in strict mode.
            if (strict || cur.w || cur.addr != 8'h02) begin
                if (exp_q.size() == 0) begin
                    fail_msg($sformatf("bus_op: got unexpected op %h, required none", cur));
                end else begin
                    e = exp_q.pop_front();
                    check("bus_op", cur, e);
                end
            end
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (tx_ready) return;
        end
        fail_msg($sformatf("%s: tx_ready still 0 after %0d cycles, required 1", name, budget));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_strobes"}, {71'b0, csr_if.wen, csr_if.ren}, 73'b0);
        check({name, "_addrs"}, {57'b0, csr_if.wr_addr, csr_if.rd_addr}, 73'b0);
        check({name, "_wdata"}, {41'b0, csr_if.wr_data}, 73'b0);
        check({name, "_tx_ready"}, {72'b0, tx_ready}, 73'b0);
        check({name, "_rx"}, {64'b0, rx_valid, rx_data}, 73'b0);
        check({name, "_flags"}, {71'b0, parity_err, init_done}, 73'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_vec_t tx_tab[4];
        rx_vec_t rx_tab[3];
        int      c0, s0, o0, lat, highs;
        bit      got;

        tx_tab[0] = '{8'hA5, 3, 11};
        tx_tab[1] = '{8'h00, 0, 5};
        tx_tab[2] = '{8'hFF, 1, 7};
        tx_tab[3] = '{8'h5A, 2, 9};
        rx_tab[0] = '{32'h0000_0001, 32'h0000_003C, 8'h3C};
        rx_tab[1] = '{32'h0000_0001, 32'hFFFF_FFA7, 8'hA7};
        rx_tab[2] = '{32'h0000_0101, 32'h5A00_0011, 8'h11};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        // Reset values and init sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        strict = 1'b1;
        exp_op(1'b1, 8'h00, 32'd5208);
        exp_op(1'b1, 8'h01, 32'h8);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("init_done_during_init", {72'b0, init_done}, 73'b0);
        @(negedge clk);
        @(negedge clk);
        check("init_done_after_init", {72'b0, init_done}, 73'd1);
        check("tx_ready_after_init", {72'b0, tx_ready}, 73'd1);
        #1 check("init_queue_empty", 73'(exp_q.size()), 73'd0);
        strict = 1'b0;

        // Table-driven tx bytes with varying busy polls
        foreach (tx_tab[i]) begin
            wait_ready("tx_wait", 60);
            busy_cfg = tx_tab[i].busy;
            exp_op(1'b1, 8'h03, {24'h0, tx_tab[i].data});
            exp_op(1'b1, 8'h01, 32'h9);
            for (int k = 0; k <= tx_tab[i].busy; k++) exp_op(1'b0, 8'h01, 32'h0);
            c0       = ctrl_rd_cnt;
            tx_data  = tx_tab[i].data;
            tx_valid = 1'b1;
            @(posedge clk);
            #1 tx_valid = 1'b0;
            got = 1'b0;
            lat = 0;
            for (int n = 1; n <= 100 && !got; n++) begin
                @(negedge clk);
                if (tx_ready) begin
                    got = 1'b1;
                    lat = n;
                end
            end
            if (!got) fail_msg("tx_latency: tx_ready never returned, required return");
            else check("tx_latency", 73'(lat), 73'(tx_tab[i].lat));
            #1;
            check("tx_queue_empty", 73'(exp_q.size()), 73'd0);
            check("tx_ctrl_reads", 73'(ctrl_rd_cnt - c0), 73'(tx_tab[i].busy + 1));
        end

        // Table-driven rx bytes, each held against a stalled consumer
        foreach (rx_tab[i]) begin
            wait_ready("rx_wait", 60);
            rx_stat = rx_tab[i].stat;
            rx_val  = rx_tab[i].rdv;
            rx_req++;
            strict = 1'b1;
            exp_op(1'b0, 8'h02, 32'h0);
            exp_op(1'b0, 8'h04, 32'h0);
            got = 1'b0;
            for (int n = 0; n < 60 && !got; n++) begin
                @(negedge clk);
                if (rx_valid) got = 1'b1;
            end
            if (!got) fail_msg("rx_valid: stayed 0 for 60 cycles, required 1");
            check("rx_data", {65'b0, rx_data}, {65'b0, rx_tab[i].exp_data});
            #1 check("rx_queue_empty", 73'(exp_q.size()), 73'd0);
            o0 = op_cnt;
            repeat (10) @(negedge clk);
            #1;
            check("rx_hold_no_ops", 73'(op_cnt - o0), 73'd0);
            check("rx_hold_valid", {72'b0, rx_valid}, 73'd1);
            rx_ready = 1'b1;
            @(posedge clk);
            #1 rx_ready = 1'b0;
            @(negedge clk);
            check("rx_valid_cleared", {72'b0, rx_valid}, 73'd0);
            check("rx_back_idle", {72'b0, tx_ready}, 73'd1);
            check("rx_no_parity", {72'b0, parity_err}, 73'd0);
            strict = 1'b0;
        end

        // Parity error without data: sticky across later clean polls
        wait_ready("perr_wait", 60);
        rx_stat = 32'h2;
        rx_req++;
        strict = 1'b1;
        exp_op(1'b0, 8'h02, 32'h0);
        #1 s0 = stat_cnt;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            #1 if (stat_cnt > s0) got = 1'b1;
        end
        if (!got) fail_msg("perr_poll: no status read in 60 cycles, required one");
        repeat (2) @(negedge clk);
        check("parity_err_set", {72'b0, parity_err}, 73'd1);
        check("perr_rx_valid", {72'b0, rx_valid}, 73'd0);
        #1 check("perr_queue_empty", 73'(exp_q.size()), 73'd0);
        strict = 1'b0;
        s0 = stat_cnt;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            #1 if (stat_cnt >= s0 + 2) got = 1'b1;
        end
        if (!got) fail_msg("perr_clean_polls: fewer than 2 polls in 100 cycles, required 2");
        repeat (2) @(negedge clk);
        check("parity_err_sticky", {72'b0, parity_err}, 73'd1);

        // Poll expiry in the same cycle tx_valid rises: status read goes first
        wait_ready("prio_wait", 60);
        #1 s0 = stat_cnt;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            #1 if (stat_cnt > s0) got = 1'b1;
        end
        if (!got) fail_msg("prio_sync: no status read in 60 cycles, required one");
        highs = 0;
        for (int n = 0; n < 40 && highs < 16; n++) begin
            @(negedge clk);
            if (tx_ready) highs++;
        end
        check("prio_idle_cycles", 73'(highs), 73'd16);
        @(posedge clk);
        #1;
        strict   = 1'b1;
        busy_cfg = 0;
        exp_op(1'b0, 8'h02, 32'h0);
        exp_op(1'b1, 8'h03, 32'hC3);
        exp_op(1'b1, 8'h01, 32'h9);
        exp_op(1'b0, 8'h01, 32'h0);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        check("prio_tx_ready_low", {72'b0, tx_ready}, 73'd0);
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (tx_ready) begin
                got = 1'b1;
                lat = n;
            end
        end
        if (!got) fail_msg("prio_accept: tx_ready never returned, required return");
        else check("prio_accept_delay", 73'(lat), 73'd3);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        wait_ready("prio_done", 60);
        #1 check("prio_queue_empty", 73'(exp_q.size()), 73'd0);
        strict = 1'b0;

        // Reset while polling send_data: outputs clear, init replays
        wait_ready("rst_wait", 60);
        busy_cfg = 5;
        exp_op(1'b1, 8'h03, 32'h77);
        exp_op(1'b1, 8'h01, 32'h9);
        for (int k = 0; k < 6; k++) exp_op(1'b0, 8'h01, 32'h0);
        c0       = ctrl_rd_cnt;
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            #1 if (ctrl_rd_cnt >= c0 + 2) got = 1'b1;
        end
        if (!got) fail_msg("rst_sync: no second control read in 30 cycles, required one");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        exp_q.delete();
        strict = 1'b1;
        exp_op(1'b1, 8'h00, 32'd5208);
        exp_op(1'b1, 8'h01, 32'h8);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reinit_done", {72'b0, init_done}, 73'd1);
        check("reinit_tx_ready", {72'b0, tx_ready}, 73'd1);
        #1 check("reinit_queue_empty", 73'(exp_q.size()), 73'd0);
        strict = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
